// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings, enable constants and
// the supported data-bit range.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_INTERVAL  = 5'b00001,
    ST_STARTBIT  = 5'b00010,
    ST_DATABITS  = 5'b00100,
    ST_PARITYBIT = 5'b01000,
    ST_STOPBIT   = 5'b10000
  } state_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter for triple-redundant registers.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit core: framing FSM, shift register and one-byte holding buffer.
// State and bit counter are triplicated and majority voted.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_Enable_i,
  input  logic                 BaudSig_i,
  input  logic [DATA_BITS-1:0] Data_i,
  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic                 p_ParityEnable_i,
  input  logic                 p_ParityOdd_i,
  input  logic                 p_TwoStop_i,
  output logic                 Tx_o,
  output logic [4:0]           State_o,
  output logic [3:0]           BitCounter_o,
  output logic                 ByteDone_o
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_fsm: DATA_BITS out of range");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [4:0]           state_q0, state_q1, state_q2, state_v, state_d;
  logic [3:0]           cnt_q0, cnt_q1, cnt_q2, cnt_v, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, buf_q, buf_d;
  logic                 full_q, full_d;
  logic                 tx_q, tx_d;
  logic                 stop_q, stop_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 parity_q, parity_d;
  logic                 start;
  logic                 done;

  tmr_vote #(.W(5)) u_vote_state (
    .a (state_q0),
    .b (state_q1),
    .c (state_q2),
    .y (state_v)
  );

  tmr_vote #(.W(4)) u_vote_cnt (
    .a (cnt_q0),
    .b (cnt_q1),
    .c (cnt_q2),
    .y (cnt_v)
  );

  always_comb begin
    state_d    = state_v;
    cnt_d      = cnt_v;
    shift_d    = shift_q;
    buf_d      = buf_q;
    full_d     = full_q;
    tx_d       = tx_q;
    stop_d     = stop_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    parity_d   = parity_q;
    start      = 1'b0;
    done       = 1'b0;

    if (Valid_i && !full_q) begin
      buf_d  = Data_i;
      full_d = 1'b1;
    end

    case (state_v)
      ST_INTERVAL: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (BaudSig_i && full_q && p_Enable_i == ENABLE) start = 1'b1;
      end
      ST_STARTBIT: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          state_d = ST_DATABITS;
          tx_d    = shift_q[0];
        end
      end
      ST_DATABITS: begin
        if (BaudSig_i) begin
          // >= rather than == so a corrupted counter still terminates the frame
          if (cnt_v >= LAST_BIT) begin
            cnt_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITYBIT;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOPBIT;
              tx_d    = 1'b1;
              stop_d  = two_stop_q;
            end
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_v + 4'd1;
            tx_d    = shift_d[0];
          end
        end
      end
      ST_PARITYBIT: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          state_d = ST_STOPBIT;
          tx_d    = 1'b1;
          stop_d  = two_stop_q;
        end
      end
      ST_STOPBIT: begin
        cnt_d = '0;
        if (BaudSig_i) begin
          if (stop_q) begin
            stop_d = 1'b0;
          end else begin
            done = 1'b1;
            if (full_q && p_Enable_i == ENABLE) begin
              start = 1'b1;
            end else begin
              state_d = ST_INTERVAL;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_INTERVAL;
        tx_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // Frame start: config and parity are frozen here for the whole frame
    if (start) begin
      state_d    = ST_STARTBIT;
      tx_d       = 1'b0;
      cnt_d      = '0;
      shift_d    = buf_q;
      full_d     = 1'b0;
      par_en_d   = p_ParityEnable_i;
      two_stop_d = p_TwoStop_i;
      parity_d   = p_ParityOdd_i ? ~^buf_q : ^buf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q0   <= ST_INTERVAL;
      state_q1   <= ST_INTERVAL;
      state_q2   <= ST_INTERVAL;
      cnt_q0     <= '0;
      cnt_q1     <= '0;
      cnt_q2     <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      tx_q       <= 1'b1;
      stop_q     <= 1'b0;
      par_en_q   <= DISABLE;
      two_stop_q <= DISABLE;
      parity_q   <= 1'b0;
    end else begin
      state_q0   <= state_d;
      state_q1   <= state_d;
      state_q2   <= state_d;
      cnt_q0     <= cnt_d;
      cnt_q1     <= cnt_d;
      cnt_q2     <= cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      tx_q       <= tx_d;
      stop_q     <= stop_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      parity_q   <= parity_d;
    end
  end

  assign Ready_o      = ~full_q;
  assign Tx_o         = tx_q;
  assign State_o      = state_v;
  assign BitCounter_o = cnt_v;
  assign ByteDone_o   = done;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: framing, parity, stop bits, back-to-back,
// enable gating, TMR fault tolerance and async reset.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       baud = 1'b0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       ready;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       tx;
  logic [4:0] state;
  logic [3:0] bitcnt;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_DATA = 5'b00100;
  localparam logic [4:0] S_STOP = 5'b10000;

  uart_tx_fsm #(.DATA_BITS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .p_Enable_i       (en),
    .BaudSig_i        (baud),
    .Data_i           (data),
    .Valid_i          (valid),
    .Ready_o          (ready),
    .p_ParityEnable_i (par_en),
    .p_ParityOdd_i    (par_odd),
    .p_TwoStop_i      (two_stop),
    .Tx_o             (tx),
    .State_o          (state),
    .BitCounter_o     (bitcnt),
    .ByteDone_o       (done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (15) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_baud();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (baud !== 1'b1 && n < 40);
    #1;
    if (n >= 40) chk("baud_wait", 32'(n), 32'd0);
  endtask

  task automatic load(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data = b;
    valid = 1'b1;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("load_wait", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // bits[0] is the start bit, bits[1..8] data LSB first, then parity/stop
  task automatic chk_bits(input string tag, input logic [15:0] bits, input int lo, input int hi,
                          input bool_ready_zero);
    for (int i = lo; i <= hi; i++) begin
      wait_baud();
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(bits[i]));
      chk($sformatf("%s_cnt%0d", tag, i), 32'(bitcnt),
          (i >= 1 && i <= 8) ? 32'(i - 1) : 32'd0);
      if (bool_ready_zero) chk($sformatf("%s_rdy%0d", tag, i), 32'(ready), 32'd0);
    end
  endtask

  task automatic chk_two_stop(input string tag);
    int n = 0;
    logic all_high = 1'b1;
    wait_baud();
    chk({tag, "_stop_state"}, 32'(state), 32'(S_STOP));
    while (state === S_STOP && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (state === S_STOP && tx !== 1'b1) all_high = 1'b0;
    end
    chk({tag, "_stop_clks"}, 32'(n), 32'd32);
    chk({tag, "_stop_high"}, 32'(all_high), 32'd1);
    chk({tag, "_end_state"}, 32'(state), 32'(S_IDLE));
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(bitcnt), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_state", 32'(state), 32'(S_IDLE));
    chk("idle_done_cnt", 32'(done_cnt), 32'd0);

    // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
    d0 = done_cnt;
    load(8'hA5);
    chk_bits("a5", 16'b0000_0011_0100_1010, 0, 9, 1'b0);
    wait_baud();
    chk("a5_end_state", 32'(state), 32'(S_IDLE));
    chk("a5_end_tx", 32'(tx), 32'd1);
    chk("a5_done", 32'(done_cnt - d0), 32'd1);

    // 0x03, even parity, two stop: parity bit 0
    par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b1;
    d0 = done_cnt;
    load(8'h03);
    chk_bits("p_even", 16'b0000_0000_0000_0110, 0, 9, 1'b0);
    chk_two_stop("p_even");
    chk("p_even_done", 32'(done_cnt - d0), 32'd1);

    // 0x03, odd parity, two stop; config changes mid-frame are ignored
    par_odd = 1'b1;
    d0 = done_cnt;
    load(8'h03);
    chk_bits("p_odd", 16'b0000_0010_0000_0110, 0, 0, 1'b0);
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    chk_bits("p_odd", 16'b0000_0010_0000_0110, 1, 9, 1'b0);
    chk_two_stop("p_odd");
    chk("p_odd_done", 32'(done_cnt - d0), 32'd1);

    // back-to-back 0x55 then 0xAA, no idle bit between frames
    d0 = done_cnt;
    load(8'h55);
    wait_baud();
    chk("b2b_start1", 32'(state), 32'(S_START));
    chk("b2b_ready_after_start", 32'(ready), 32'd1);
    load(8'hAA);
    chk("b2b_ready_after_load", 32'(ready), 32'd0);
    chk_bits("b2b_55", 16'b0000_0010_1010_1010, 1, 9, 1'b1);
    wait_baud();
    chk("b2b_start2", 32'(state), 32'(S_START));
    chk("b2b_start2_tx", 32'(tx), 32'd0);
    chk("b2b_ready2", 32'(ready), 32'd1);
    chk("b2b_done1", 32'(done_cnt - d0), 32'd1);
    chk_bits("b2b_aa", 16'b0000_0011_0101_0100, 1, 9, 1'b0);
    wait_baud();
    chk("b2b_end", 32'(state), 32'(S_IDLE));
    chk("b2b_done2", 32'(done_cnt - d0), 32'd2);

    // enable dropped mid-frame: frame completes, queued byte held
    load(8'h3C);
    wait_baud();
    load(8'hC3);
    chk_bits("en_3c", 16'b0000_0010_0111_1000, 1, 3, 1'b1);
    en = 1'b0;
    chk_bits("en_3c", 16'b0000_0010_0111_1000, 4, 9, 1'b1);
    wait_baud();
    chk("en_off_state", 32'(state), 32'(S_IDLE));
    chk("en_off_ready", 32'(ready), 32'd0);
    repeat (2) wait_baud();
    chk("en_held_state", 32'(state), 32'(S_IDLE));
    chk("en_held_tx", 32'(tx), 32'd1);
    en = 1'b1;
    wait_baud();
    chk("en_restart_state", 32'(state), 32'(S_START));
    chk("en_restart_tx", 32'(tx), 32'd0);
    chk_bits("en_c3", 16'b0000_0011_1000_0110, 1, 9, 1'b0);
    wait_baud();
    chk("en_c3_end", 32'(state), 32'(S_IDLE));

    // one corrupted state copy is outvoted
    load(8'h5A);
    chk_bits("tmr1", 16'b0000_0010_1011_0100, 0, 3, 1'b0);
    force dut.state_q1 = 5'b01000;
    @(posedge clk); #1;
    chk("tmr1_state", 32'(state), 32'(S_DATA));
    chk("tmr1_tx", 32'(tx), 32'd0);
    release dut.state_q1;
    @(posedge clk); #1;
    chk("tmr1_rewrite", 32'(dut.state_q1), 32'(S_DATA));
    chk_bits("tmr1", 16'b0000_0010_1011_0100, 4, 9, 1'b0);
    wait_baud();
    chk("tmr1_end", 32'(state), 32'(S_IDLE));

    // two copies corrupted: voted state invalid -> INTERVAL, buffer kept
    load(8'h66);
    wait_baud();
    load(8'h99);
    chk_bits("tmr2", 16'b0000_0010_1100_1100, 1, 2, 1'b1);
    force dut.state_q0 = 5'b00011;
    force dut.state_q1 = 5'b00011;
    @(posedge clk); #1;
    chk("tmr2_tx", 32'(tx), 32'd1);
    chk("tmr2_cnt", 32'(bitcnt), 32'd0);
    release dut.state_q0;
    release dut.state_q1;
    @(posedge clk); #1;
    chk("tmr2_state", 32'(state), 32'(S_IDLE));
    chk("tmr2_ready", 32'(ready), 32'd0);
    wait_baud();
    chk("tmr2_restart", 32'(state), 32'(S_START));
    chk_bits("tmr2_99", 16'b0000_0011_0011_0010, 1, 9, 1'b0);
    wait_baud();
    chk("tmr2_end", 32'(state), 32'(S_IDLE));

    // async reset mid-frame discards frame and queued byte
    load(8'h00);
    wait_baud();
    load(8'hFF);
    chk_bits("rst_mid", 16'b0000_0010_0000_0000, 1, 2, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_state", 32'(state), 32'(S_IDLE));
    chk("rstmid_ready", 32'(ready), 32'd1);
    chk("rstmid_cnt", 32'(bitcnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_baud();
      chk($sformatf("rstpost_state%0d", k), 32'(state), 32'(S_IDLE));
      chk($sformatf("rstpost_tx%0d", k), 32'(tx), 32'd1);
      chk($sformatf("rstpost_ready%0d", k), 32'(ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
